pipe_referee: RTL
=================

# pipe_referee

Game-rule engine for the pipes playfield. It generates the gap height consumed by the pipe renderer (`PipesLong`) and reads back the renderer's scrolling position (`PipesPosition`). It judges bird/pipe and bird/floor collisions, keeps a two-digit BCD score, and drives the `Status` run/freeze flag that gates pipe scrolling. It sits between the bird-motion logic and the pipe renderer, in the `clk` domain.

## Interface
Parameters:
- `SCREEN_W`, 640: pipe respawn X; value seen on `PipesPosition` at wrap.
- `PIPE_W`, 90: pipe cap width in pixels.
- `CAP_H`, 33: top-pipe cap height below `PipesLong`.
- `GAP`, 150: offset from top-pipe Y to bottom-pipe Y.
- `FLOOR_Y`, 428: floor line.
- `BIRD_X`, 200: fixed bird left edge.
- `BIRD_W`, 34: bird width.
- `BIRD_H`, 24: bird height.
- `MIN_LONG`, 40: minimum `PipesLong`.
- `SPAN`, 199: number of legal `PipesLong` values (40..238).

Ports:
- `clk`, in, 1: system clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Button`, in, 1: flap/start button, active-low, already synchronised to `clk`.
- `PipesPosition`, in, 16: current pipe left X from the renderer.
- `BirdY`, in, 16: bird top Y from the bird-motion block.
- `PipesLong`, out, 16: top-pipe bottom Y; registered.
- `Status`, out, 1: 1 = world scrolls, 0 = frozen (dead).
- `Score`, out, 8: BCD, [7:4] tens, [3:0] units.
- `DeathPulse`, out, 1: single-cycle strobe on entry to DEAD.

## Operation
- States: IDLE, RUN, DEAD.
  - IDLE→RUN on a button press. A press is `Button` going 1→0 between consecutive cycles, detected with a registered previous value.
  - RUN→DEAD on collision.
  - DEAD→IDLE on a press.
- Score:
  - Cleared to 00 on IDLE→RUN.
  - Held in IDLE and DEAD.
- `Status` = 0 only in DEAD.
- Gap generation:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advances every cycle.
  - r = lfsr[7:0]. Candidate = `MIN_LONG` + (r < `SPAN` ? r : r − `SPAN`).
  - The candidate is loaded into `PipesLong` on a wrap event: `PipesPosition` == `SCREEN_W` while the previous-cycle value != `SCREEN_W`.
  - Wrap events are honoured in every state. `PipesLong` is otherwise held.
- Collision, evaluated every cycle in RUN only. All sums use 17-bit arithmetic, with no wrap.
  - xhit = (`BIRD_X` + `BIRD_W` ≥ `PipesPosition`) && (`BIRD_X` ≤ `PipesPosition` + `PIPE_W`).
  - yhit = (`BirdY` ≤ `PipesLong` + `CAP_H`) || (`BirdY` + `BIRD_H` ≥ `PipesLong` + `GAP`).
  - floor = `BirdY` + `BIRD_H` ≥ `FLOOR_Y`.
  - collision = (xhit && yhit) || floor.
- Scoring in RUN:
  - A pass occurs when `PipesPosition` + `PIPE_W` < `BIRD_X` and the `passed` flag is 0.
  - A pass sets `passed` and increments `Score` in BCD, saturating at 99.
  - `passed` is cleared on every wrap event.
- Priorities within a cycle:
  - collision beats pass: no increment on the death cycle.
  - wrap and collision in the same cycle both take effect.
  - wrap and pass in the same cycle cannot both be true, since `SCREEN_W` + `PIPE_W` > `BIRD_X`.

## Timing
- Reset values:
  - state IDLE.
  - `PipesLong` = 139.
  - `Status` = 1.
  - `Score` = 8'h00.
  - `DeathPulse` = 0.
  - lfsr = 16'hACE1.
  - `passed` = 0.
  - previous-`Button` = 1.
  - previous-`PipesPosition` = `SCREEN_W`.
- Every output is registered. Input change to output response takes 1 `clk` cycle.
- `DeathPulse` is high exactly in the cycle after the colliding cycle, concurrent with `Status` falling.
- A held-low `Button` gives exactly one press. Leaving DEAD requires a release and then a new press.
- An asynchronous `Reset` mid-game returns immediately to the reset values. The score is lost.
- `PipesLong` never changes except at a wrap event, so it is stable for the whole pipe traversal.

## Structure
- Shared package `pipes_pkg` holds the geometry constants (`SCREEN_W`, `PIPE_W`, `CAP_H`, `GAP`, `FLOOR_Y`, `BIRD_*`) and the state enum {IDLE, RUN, DEAD}. The renderer and this block use the same values from it.
- Sub-module `pipe_lfsr` (clk, Reset, 16-bit out, seed parameter). It is reusable for other random placements.
- The BCD saturating incrementer stays inline.

## Test plan
- Reset, then hold `Button`=1 for 100 cycles. Required: `Status`=1, `Score`=00, `PipesLong`=139, state IDLE.
- Press, `BirdY`=200, `PipesLong`=139, sweep `PipesPosition` 640→0. Required: `Score` 00→01 exactly once, at the cycle after `PipesPosition` goes below 110; no death.
- RUN, `BirdY`=150, `PipesPosition`=150 (top-cap hit: 150 ≤ 172). Required: `DeathPulse` one cycle, `Status`=0 next cycle, score frozen.
- RUN, `PipesPosition`=600, `BirdY`=405 (floor: 405+24 ≥ 428). Required: DEAD. Then hold `Button`=0 across the transition. Required: stays DEAD until release and re-press, then IDLE; the next press clears `Score`.
- Drive `PipesPosition` 1→640 a total of 1000 times. Required: `PipesLong` updates only on those cycles and is always in 40..238; exact values match the LFSR reference model.
- Force score to 99 and produce a pass. Required: `Score` stays 8'h99. Separately, assert `Reset` mid-RUN. Required: all outputs return to reset values immediately.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared playfield geometry and game state encoding for the pipes renderer and referee.
package pipes_pkg;

    localparam int unsigned SCREEN_W  = 640;  // pipe respawn X
    localparam int unsigned PIPE_W    = 90;
    localparam int unsigned CAP_H     = 33;
    localparam int unsigned GAP       = 150;  // top-pipe Y to bottom-pipe Y
    localparam int unsigned FLOOR_Y   = 428;
    localparam int unsigned BIRD_X    = 200;
    localparam int unsigned BIRD_W    = 34;
    localparam int unsigned BIRD_H    = 24;
    localparam int unsigned MIN_LONG  = 40;
    localparam int unsigned SPAN      = 199;  // legal PipesLong values: MIN_LONG .. MIN_LONG+SPAN-1
    localparam int unsigned LONG_INIT = 139;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reusable for random placements.
module pipe_lfsr
    import pipes_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        Reset,
    output logic [15:0] Value
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign Value      = r_lfsr;

    // Shift left every cycle, feedback enters at bit 0.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

endmodule

// File: rtl/pipe_referee.sv
// Game-rule engine: gap generation, collision judging, BCD scoring and run/freeze status.
module pipe_referee #(
    parameter int unsigned SCREEN_W = pipes_pkg::SCREEN_W,
    parameter int unsigned PIPE_W   = pipes_pkg::PIPE_W,
    parameter int unsigned CAP_H    = pipes_pkg::CAP_H,
    parameter int unsigned GAP      = pipes_pkg::GAP,
    parameter int unsigned FLOOR_Y  = pipes_pkg::FLOOR_Y,
    parameter int unsigned BIRD_X   = pipes_pkg::BIRD_X,
    parameter int unsigned BIRD_W   = pipes_pkg::BIRD_W,
    parameter int unsigned BIRD_H   = pipes_pkg::BIRD_H,
    parameter int unsigned MIN_LONG = pipes_pkg::MIN_LONG,
    parameter int unsigned SPAN     = pipes_pkg::SPAN
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Button,
    input  logic [15:0] PipesPosition,
    input  logic [15:0] BirdY,
    output logic [15:0] PipesLong,
    output logic        Status,
    output logic [7:0]  Score,
    output logic        DeathPulse
);

    // 17-bit geometry so that no sum below can wrap.
    localparam logic [16:0] L_PIPE_W  = 17'(PIPE_W);
    localparam logic [16:0] L_CAP_H   = 17'(CAP_H);
    localparam logic [16:0] L_GAP     = 17'(GAP);
    localparam logic [16:0] L_FLOOR_Y = 17'(FLOOR_Y);
    localparam logic [16:0] L_BIRD_X  = 17'(BIRD_X);
    localparam logic [16:0] L_BIRD_XR = 17'(BIRD_X + BIRD_W);
    localparam logic [16:0] L_BIRD_H  = 17'(BIRD_H);

    pipes_pkg::state_e r_state, w_state_next;

    logic [15:0] r_pipes_long;
    logic [15:0] r_pos_prev;
    logic        r_btn_prev;
    logic        r_passed, w_passed_next;
    logic [7:0]  r_score, w_score_next, w_score_inc;
    logic        r_status;
    logic        r_death;

    logic [15:0] w_lfsr;
    logic [7:0]  w_rnd, w_rnd_wrapped;
    logic [15:0] w_gap_cand;
    logic        w_unused_lfsr;
    logic        w_press, w_wrap;
    logic [16:0] w_pos, w_bird, w_long;
    logic        w_xhit, w_yhit, w_floor, w_collision, w_pass;

    pipe_lfsr #(
        .SEED (pipes_pkg::LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .Reset (Reset),
        .Value (w_lfsr)
    );

    // Only the low byte picks the gap; upper bits just keep the sequence long.
    assign w_rnd         = w_lfsr[7:0];
    assign w_unused_lfsr = ^w_lfsr[15:8];
    assign w_rnd_wrapped = (w_rnd < 8'(SPAN)) ? w_rnd : w_rnd - 8'(SPAN);
    assign w_gap_cand    = 16'(MIN_LONG) + {8'd0, w_rnd_wrapped};

    assign w_press = r_btn_prev & ~Button;
    assign w_wrap  = (PipesPosition == 16'(SCREEN_W)) && (r_pos_prev != 16'(SCREEN_W));

    assign w_pos  = {1'b0, PipesPosition};
    assign w_bird = {1'b0, BirdY};
    assign w_long = {1'b0, r_pipes_long};

    assign w_xhit      = (L_BIRD_XR >= w_pos) && (L_BIRD_X <= w_pos + L_PIPE_W);
    assign w_yhit      = (w_bird <= w_long + L_CAP_H) || (w_bird + L_BIRD_H >= w_long + L_GAP);
    assign w_floor     = (w_bird + L_BIRD_H >= L_FLOOR_Y);
    assign w_collision = (w_xhit && w_yhit) || w_floor;
    assign w_pass      = (w_pos + L_PIPE_W < L_BIRD_X) && !r_passed;

    // Saturating two-digit BCD increment.
    always_comb begin
        w_score_inc = r_score;
        if (r_score == 8'h99) begin
            w_score_inc = r_score;
        end else if (r_score[3:0] == 4'd9) begin
            w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
        end else begin
            w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
        end
    end

    // Next state, score and pass flag; collision takes priority over a pass.
    always_comb begin
        w_state_next  = r_state;
        w_score_next  = r_score;
        w_passed_next = r_passed;
        if (w_wrap) begin
            w_passed_next = 1'b0;
        end
        case (r_state)
            pipes_pkg::IDLE: begin
                if (w_press) begin
                    w_state_next = pipes_pkg::RUN;
                    w_score_next = 8'h00;
                end
            end
            pipes_pkg::RUN: begin
                if (w_collision) begin
                    w_state_next = pipes_pkg::DEAD;
                end else if (w_pass) begin
                    w_passed_next = 1'b1;
                    w_score_next  = w_score_inc;
                end
            end
            pipes_pkg::DEAD: begin
                if (w_press) begin
                    w_state_next = pipes_pkg::IDLE;
                end
            end
            default: w_state_next = pipes_pkg::IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= pipes_pkg::IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered outputs, pass flag and edge-detect history.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_pipes_long <= 16'(pipes_pkg::LONG_INIT);
            r_pos_prev   <= 16'(SCREEN_W);
            r_btn_prev   <= 1'b1;
            r_passed     <= 1'b0;
            r_score      <= 8'h00;
            r_status     <= 1'b1;
            r_death      <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_pipes_long <= w_gap_cand;
            end
            r_pos_prev <= PipesPosition;
            r_btn_prev <= Button;
            r_passed   <= w_passed_next;
            r_score    <= w_score_next;
            r_status   <= (w_state_next != pipes_pkg::DEAD);
            r_death    <= (r_state == pipes_pkg::RUN) && w_collision;
        end
    end

    assign PipesLong  = r_pipes_long;
    assign Status     = r_status;
    assign Score      = r_score;
    assign DeathPulse = r_death;

endmodule
